seq_comp: RTL and testbench
===========================

SEQ_COMP -- requirements
Module: seq_comp

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 Parameter EARLY_EXIT, default 1: 1 = finish at first differing chunk; 0 = always run all NCHUNK chunks.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 start  input  1  request a compare; accepted only when busy=0.
REQ-007 is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled at acceptance.
REQ-008 zero  input  1  1 = B is replaced by 0 (compare A against zero); sampled at acceptance.
REQ-009 A  input  WIDTH  left operand; sampled at acceptance.
REQ-010 B  input  WIDTH  right operand; sampled at acceptance.
REQ-011 busy  output  1  high while a compare is in progress.
REQ-012 done  output  1  single-cycle pulse marking a valid new Comp_Out.
REQ-013 Comp_Out  output  3  one-hot result {gt, eq, lt}: 100 A>B, 010 A==B, 001 A<B, 000 no result.

Function
REQ-014 States SHALL be IDLE and RUN; busy=1 exactly in RUN.
REQ-015 IDLE + start=1 on an edge SHALL latch A, B (or 0 if zero=1) and is_signed, clear Comp_Out to 000, set chunk index k=0, and enter RUN.
REQ-016 In signed mode, the sign bit (bit WIDTH-1) of both latched operands SHALL be inverted at latch time; all chunk compares are then unsigned.
REQ-017 In RUN, each cycle compares chunk k (k=0 is bits WIDTH-1..WIDTH-CHUNK, most significant first) and increments k.
REQ-018 A chunk with A>B SHALL decide 100; with A<B SHALL decide 001; with EARLY_EXIT=1 the decision is registered on that edge, done pulses, and the state returns to IDLE.
REQ-019 With EARLY_EXIT=0, the first differing chunk SHALL be recorded internally, later chunks SHALL NOT override it, and completion occurs only after chunk NCHUNK-1.
REQ-020 All chunks equal SHALL decide 010 after chunk NCHUNK-1.
REQ-021 Latency: with the start edge at e0 and the deciding chunk i, Comp_Out and done SHALL be valid after edge e0+i+1; the eq case, and every case with EARLY_EXIT=0, takes exactly NCHUNK cycles.
REQ-022 done SHALL be high for exactly one cycle per accepted start; Comp_Out SHALL hold its value until the next accepted start.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the latched operands or on the result.
REQ-024 start high in the cycle where done=1 (state IDLE) SHALL be accepted: back-to-back operation with no idle gap.
REQ-025 Input changes after acceptance SHALL NOT affect the result in progress.
REQ-026 k SHALL be sized clog2(NCHUNK), minimum 1 bit, and SHALL never exceed NCHUNK-1.

Reset
REQ-027 reset=0 on an edge SHALL force IDLE, busy=0, done=0, Comp_Out=000, k=0, regardless of state, including mid-RUN; the aborted compare produces no done.
REQ-028 reset has priority over start in the same cycle.

Verification (WIDTH=32, CHUNK=8)
REQ-029 is_signed=1, A=0xFFFFFFFF, B=0x00000001 -> Comp_Out=001, done 1 cycle after start.
REQ-030 is_signed=0, same operands -> Comp_Out=100, done 1 cycle after start.
REQ-031 A=B=0x12345678, either mode -> Comp_Out=010, done 4 cycles after start.
REQ-032 zero=1, A=0x00000001, B=0xFFFFFFFF -> Comp_Out=100, done 4 cycles after start; then is_signed=1, zero=1, A=0x80000000 -> 001 in 1 cycle.
REQ-033 Mid-RUN: start pulse ignored and result unchanged; a separate run with reset=0 at cycle 2 -> busy=0, Comp_Out=000, no done.
REQ-034 EARLY_EXIT=0, operands as in REQ-029 -> Comp_Out=001, done exactly 4 cycles after start; back-to-back start on the done cycle accepted.

Source files
------------

// File: rtl/seq_comp.sv
// rtl/seq_comp.sv - sequential chunk-serial magnitude comparator, MSB chunk first
// Signed compares are reduced to unsigned by flipping both sign bits when the operands are latched.
module seq_comp #(
   parameter int WIDTH      = 32,
   parameter int CHUNK      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic             zero,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [2:0]       Comp_Out
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   localparam logic [2:0] RES_GT = 3'b100;
   localparam logic [2:0] RES_EQ = 3'b010;
   localparam logic [2:0] RES_LT = 3'b001;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic [2:0]       comp_q, comp_d;
   logic             done_q, done_d;
   logic [2:0]       pend_q, pend_d;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [2:0]       chunk_dec;
   logic [2:0]       decision;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         comp_q  <= 3'b000;
         done_q  <= 1'b0;
         pend_q  <= 3'b000;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         comp_q  <= comp_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
      end
   end

   // Operands shift left each RUN cycle so the chunk under test is always the top CHUNK bits.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      comp_d  = comp_q;
      done_d  = 1'b0;
      pend_d  = pend_q;

      a_chunk = a_q[WIDTH-1 -: CHUNK];
      b_chunk = b_q[WIDTH-1 -: CHUNK];
      if (a_chunk > b_chunk) begin
         chunk_dec = RES_GT;
      end else if (a_chunk < b_chunk) begin
         chunk_dec = RES_LT;
      end else begin
         chunk_dec = 3'b000;
      end
      decision = (pend_q != 3'b000) ? pend_q : chunk_dec;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d = A;
               b_d = zero ? '0 : B;
               if (is_signed) begin
                  a_d[WIDTH-1] = ~a_d[WIDTH-1];
                  b_d[WIDTH-1] = ~b_d[WIDTH-1];
               end
               comp_d  = 3'b000;
               k_d     = '0;
               pend_d  = 3'b000;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d = a_q << CHUNK;
            b_d = b_q << CHUNK;
            k_d = k_q + 1'b1;
            if ((EARLY_EXIT != 0) && (chunk_dec != 3'b000)) begin
               comp_d  = chunk_dec;
               done_d  = 1'b1;
               k_d     = '0;
               state_d = IDLE;
            end else if (k_q == K_LAST) begin
               comp_d  = (decision != 3'b000) ? decision : RES_EQ;
               done_d  = 1'b1;
               k_d     = '0;
               state_d = IDLE;
            end else begin
               pend_d = decision;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign Comp_Out = comp_q;

endmodule

// File: tb/tb_seq_comp.sv
// tb/tb_seq_comp.sv - scoreboard bench for seq_comp, early-exit and full-run instances
module tb_seq_comp;

   logic        clk;
   logic        reset;
   logic        start_ee, start_ne;
   logic        is_signed, zero;
   logic [31:0] A, B;
   logic        busy_ee, done_ee, busy_ne, done_ne;
   logic [2:0]  comp_ee, comp_ne;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] comp;
      int         lat;
   } exp_t;
   exp_t sb[$];

   seq_comp #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_ee (
      .clk(clk), .reset(reset), .start(start_ee), .is_signed(is_signed),
      .zero(zero), .A(A), .B(B), .busy(busy_ee), .done(done_ee),
      .Comp_Out(comp_ee)
   );

   seq_comp #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_ne (
      .clk(clk), .reset(reset), .start(start_ne), .is_signed(is_signed),
      .zero(zero), .A(A), .B(B), .busy(busy_ne), .done(done_ne),
      .Comp_Out(comp_ne)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(bit ne, bit sgn, bit z, logic [31:0] a, logic [31:0] b);
      exp_t e;
      logic [31:0] bb;
      logic [31:0] x;
      bb = z ? 32'h0 : b;
      if (sgn) begin
         e.comp = ($signed(a) > $signed(bb)) ? 3'b100 :
                  ($signed(a) < $signed(bb)) ? 3'b001 : 3'b010;
      end else begin
         e.comp = (a > bb) ? 3'b100 : (a < bb) ? 3'b001 : 3'b010;
      end
      x = a ^ bb;
      e.lat = 4;
      if (!ne) begin
         for (int i = 3; i >= 0; i--) begin
            if (x[i*8 +: 8] != 8'h00) begin
               e.lat = 4 - i;
               break;
            end
         end
      end
      return e;
   endfunction

   // Drives one start pulse and records the expected result; returns just after the accept edge.
   task automatic issue(bit ne, bit sgn, bit z, logic [31:0] a, logic [31:0] b);
      is_signed = sgn;
      zero      = z;
      A         = a;
      B         = b;
      sb.push_back(model(ne, sgn, z, a, b));
      if (ne) start_ne = 1'b1;
      else    start_ee = 1'b1;
      step();
      start_ne = 1'b0;
      start_ee = 1'b0;
   endtask

   task automatic wait_done(bit ne, output logic [2:0] comp, output int lat, output bit seen);
      seen = 1'b0;
      lat  = 0;
      comp = 3'bxxx;
      for (int c = 1; c <= 12; c++) begin
         step();
         if ((ne ? done_ne : done_ee) === 1'b1) begin
            seen = 1'b1;
            lat  = c;
            comp = ne ? comp_ne : comp_ee;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      checks++;
      if (busy_ee !== 1'b0 || busy_ne !== 1'b0) begin
         errors++; $display("FAIL reset_busy ee=%b ne=%b want 0", busy_ee, busy_ne);
      end
      checks++;
      if (done_ee !== 1'b0 || done_ne !== 1'b0) begin
         errors++; $display("FAIL reset_done ee=%b ne=%b want 0", done_ee, done_ne);
      end
      checks++;
      if (comp_ee !== 3'b000 || comp_ne !== 3'b000) begin
         errors++; $display("FAIL reset_comp ee=%b ne=%b want 000", comp_ee, comp_ne);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_vectors();
      logic [2:0] comp;
      int lat;
      bit seen;
      exp_t e;
      logic [31:0] va[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678,
                             32'h00000001, 32'h80000000};
      logic [31:0] vb[6] = '{32'h00000001, 32'h00000001, 32'h12345678, 32'h12345678,
                             32'hFFFFFFFF, 32'h00000005};
      bit vs[6] = '{1, 0, 0, 1, 0, 1};
      bit vz[6] = '{0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, vs[i], vz[i], va[i], vb[i]);
         checks++;
         if (busy_ee !== 1'b1) begin
            errors++; $display("FAIL vec%0d_busy got %b want 1", i, busy_ee);
         end
         wait_done(1'b0, comp, lat, seen);
         e = sb.pop_front();
         checks++;
         if (!seen || comp !== e.comp || lat != e.lat) begin
            errors++;
            $display("FAIL vec%0d_result got comp=%b lat=%0d seen=%0d want comp=%b lat=%0d",
                     i, comp, lat, seen, e.comp, e.lat);
         end
         step();
         checks++;
         if (done_ee !== 1'b0 || comp_ee !== e.comp || busy_ee !== 1'b0) begin
            errors++;
            $display("FAIL vec%0d_hold got done=%b comp=%b busy=%b want 0 %b 0",
                     i, done_ee, comp_ee, busy_ee, e.comp);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] comp;
      int lat;
      bit seen;
      exp_t e;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = a;
         if ((i % 4) != 3) b[$urandom_range(31, 0)] ^= 1'b1;
         if ((i % 6) == 5) b = $urandom;
         issue(i[0], i[1], (i % 7) == 6, a, b);
         wait_done(i[0], comp, lat, seen);
         e = sb.pop_front();
         checks++;
         if (!seen || comp !== e.comp || lat != e.lat) begin
            errors++;
            $display("FAIL rand%0d a=%h b=%h got comp=%b lat=%0d want comp=%b lat=%0d",
                     i, a, b, comp, lat, e.comp, e.lat);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [2:0] comp;
      int lat;
      bit seen;
      exp_t e;
      issue(1'b0, 1'b0, 1'b0, 32'h12345678, 32'h12345678);
      step();
      A = 32'hFFFFFFFF;
      B = 32'h00000001;
      start_ee = 1'b1;
      step();
      start_ee = 1'b0;
      wait_done(1'b0, comp, lat, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || comp !== e.comp || lat + 2 != e.lat) begin
         errors++;
         $display("FAIL busy_ignore got comp=%b lat=%0d want comp=%b lat=%0d",
                  comp, lat + 2, e.comp, e.lat);
      end
      wait_done(1'b0, comp, lat, seen);
      checks++;
      if (seen) begin
         errors++; $display("FAIL busy_ignore_extra_done got done after %0d want none", lat);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [2:0] comp;
      int lat;
      bit seen;
      issue(1'b0, 1'b1, 1'b0, 32'h12345678, 32'h12345678);
      void'(sb.pop_front());
      step();
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      checks++;
      if (busy_ee !== 1'b0 || done_ee !== 1'b0 || comp_ee !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset got busy=%b done=%b comp=%b want 0 0 000",
                  busy_ee, done_ee, comp_ee);
      end
      wait_done(1'b0, comp, lat, seen);
      checks++;
      if (seen) begin
         errors++; $display("FAIL mid_reset_done got done after %0d want none", lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] comp;
      int lat;
      bit seen;
      exp_t e;
      issue(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001);
      wait_done(1'b1, comp, lat, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || comp !== e.comp || lat != e.lat) begin
         errors++;
         $display("FAIL ne_signed got comp=%b lat=%0d want comp=%b lat=%0d",
                  comp, lat, e.comp, e.lat);
      end
      issue(1'b1, 1'b0, 1'b0, 32'h01FFFFFF, 32'h02000000);
      checks++;
      if (busy_ne !== 1'b1) begin
         errors++; $display("FAIL b2b_accept got busy=%b want 1", busy_ne);
      end
      wait_done(1'b1, comp, lat, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || comp !== e.comp || lat != e.lat) begin
         errors++;
         $display("FAIL ne_first_wins got comp=%b lat=%0d want comp=%b lat=%0d",
                  comp, lat, e.comp, e.lat);
      end
      issue(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
      wait_done(1'b0, comp, lat, seen);
      e = sb.pop_front();
      issue(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001);
      checks++;
      if (busy_ee !== 1'b1) begin
         errors++; $display("FAIL ee_b2b_accept got busy=%b want 1", busy_ee);
      end
      wait_done(1'b0, comp, lat, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || comp !== e.comp || lat != e.lat) begin
         errors++;
         $display("FAIL ee_b2b_result got comp=%b lat=%0d want comp=%b lat=%0d",
                  comp, lat, e.comp, e.lat);
      end
   endtask

   initial begin
      reset     = 1'b0;
      start_ee  = 1'b0;
      start_ne  = 1'b0;
      is_signed = 1'b0;
      zero      = 1'b0;
      A         = '0;
      B         = '0;
      test_reset();
      test_vectors();
      test_random();
      test_busy_ignore();
      test_reset_mid_run();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
